// File: rtl/fetch_pkg.sv
// Types and constants shared by the fetch queue, the PC unit and decode.
// Instruction words travel through the fetch queue tagged with the PC they were read from.
package fetch_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned INST_W = 32;

  // Fields that decode reads out of a fetched instruction word
  localparam int unsigned OP_MSB  = 27;
  localparam int unsigned OP_LSB  = 26;
  localparam int unsigned IMM_BIT = 25;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

  function automatic logic [OP_MSB-OP_LSB:0] inst_op(input logic [INST_W-1:0] inst);
    return inst[OP_MSB:OP_LSB];
  endfunction

  function automatic logic inst_imm(input logic [INST_W-1:0] inst);
    return inst[IMM_BIT];
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO of fetch entries with a combinational head and an occupancy count.
// clear empties it and takes priority over push and pop.
module inst_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  // Pointers are PW bits wide, so they wrap modulo DEPTH on their own
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr_q] <= push_data;
  end

  assign count = count_q;
  assign head  = mem[rd_ptr_q];

  a_no_push_full: assert property (@(posedge clk) disable iff (clear)
    !(push && count_q == CW'(DEPTH)));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (clear)
    !(pop && count_q == '0));

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch responder: issues 1-cycle instruction-memory reads for the PC unit and queues the
// returned words, tagged with their PC, towards decode.
module inst_fetch_queue #(
  parameter int unsigned ADDR_W = fetch_pkg::ADDR_W,
  parameter int unsigned INST_W = fetch_pkg::INST_W,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  input  logic              flush,
  output logic              stall_out,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [CW-1:0]     count
);

  if (ADDR_W != fetch_pkg::ADDR_W || INST_W != fetch_pkg::INST_W) begin : g_width_check
    $error("inst_fetch_queue: ADDR_W/INST_W must match fetch_pkg");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("inst_fetch_queue: DEPTH must be a power of two, at least 2");
  end

  logic                  inflight_v;
  logic [ADDR_W-1:0]     inflight_pc;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  clear;
  logic [CW-1:0]         fifo_count;
  fetch_pkg::fetch_entry_t push_data;
  fetch_pkg::fetch_entry_t head;

  // Credit check: a slot is reserved for the outstanding read, so a push never finds it full
  assign stall_out = (32'(fifo_count) + 32'(inflight_v)) >= DEPTH;

  assign issue     = pc_valid && !stall_out && !flush && !reset;
  assign imem_en   = issue;
  assign imem_addr = reset ? '0 : pc_in;

  assign push  = inflight_v && !flush && !reset;
  assign pop   = inst_valid && inst_ready && !flush && !reset;
  assign clear = reset || flush;

  assign push_data = '{inst: imem_rdata, pc: inflight_pc};

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      inflight_v  <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight_v <= issue;
      if (issue) inflight_pc <= pc_in;
    end
  end

  inst_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .clear    (clear),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .count    (fifo_count),
    .head     (head)
  );

  assign inst_valid = fifo_count != '0;
  assign inst_out   = reset ? '0 : head.inst;
  assign inst_pc    = reset ? '0 : head.pc;
  assign count      = fifo_count;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue with a 1-cycle instruction memory model.
module tb_inst_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   pc_in = '0;
  logic          pc_valid = 1'b0;
  logic          flush = 1'b0;
  logic          stall_out;
  logic          imem_en;
  logic [15:0]   imem_addr;
  logic [31:0]   imem_rdata = '0;
  logic [31:0]   inst_out;
  logic [15:0]   inst_pc;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic [CW-1:0] count;

  inst_fetch_queue #(
    .ADDR_W(16),
    .INST_W(32),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pc_in     (pc_in),
    .pc_valid  (pc_valid),
    .flush     (flush),
    .stall_out (stall_out),
    .imem_en   (imem_en),
    .imem_addr (imem_addr),
    .imem_rdata(imem_rdata),
    .inst_out  (inst_out),
    .inst_pc   (inst_pc),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [15:0] a);
    return 32'hA000_0000 + 32'(a);
  endfunction

  // Memory: data only meaningful the cycle after a read; otherwise noise
  always @(posedge clk) imem_rdata <= imem_en ? word(imem_addr) : $urandom();

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference: FIFO occupancy, one outstanding read, and in-order expected outputs
  int unsigned   m_count = 0;
  bit            m_infl = 1'b0;
  logic [47:0]   sb [$];
  bit            last_issue;
  logic [15:0]   pc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit v, input logic [15:0] p, input bit fl, input bit rdy, input bit rst);
    bit e_stall;
    bit e_en;
    @(negedge clk);
    pc_valid   = v;
    pc_in      = p;
    flush      = fl;
    inst_ready = rdy;
    reset      = rst;
    #1;
    e_stall = (m_count + 32'(m_infl)) >= DEPTH;
    e_en    = v && !e_stall && !fl && !rst;
    check("imem_en", 64'(imem_en), 64'(e_en));
    if (rst) begin
      check("imem_addr_rst", 64'(imem_addr), 64'd0);
      check("inst_out_rst", 64'(inst_out), 64'd0);
      check("inst_pc_rst", 64'(inst_pc), 64'd0);
    end else begin
      if (e_en) check("imem_addr", 64'(imem_addr), 64'(p));
      check("stall_out", 64'(stall_out), 64'(e_stall));
      check("count", 64'(count), 64'(m_count));
      check("inst_valid", 64'(inst_valid), 64'(m_count != 0));
    end
    if (rst || fl) begin
      m_count = 0;
      m_infl  = 1'b0;
      sb.delete();
    end else begin
      if (rdy && m_count != 0) m_count--;
      if (m_infl) m_count++;
      m_infl = e_en;
      if (e_en) sb.push_back({word(p), p});
    end
    last_issue = e_en;
  endtask

  // Monitor: every accepted head must be the oldest expected entry
  initial begin
    logic [47:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && !flush && inst_valid && inst_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 64'(inst_pc), 64'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("inst_pc", 64'(inst_pc), 64'(e[15:0]));
          check("inst_out", 64'(inst_out), 64'(e[47:16]));
        end
      end
    end
  end

  task automatic stream(input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin
      step(1'b1, pc, 1'b0, rdy, 1'b0);
      if (last_issue) pc++;
    end
  endtask

  // Stall decode until the queue holds cnt entries plus one read in flight
  task automatic fill_to(input int unsigned cnt);
    int i;
    for (i = 0; i < 20; i++) begin
      if (m_count == cnt && m_infl) break;
      step(1'b1, pc, 1'b0, 1'b0, 1'b0);
      if (last_issue) pc++;
    end
    if (i == 20) check("fill_timeout", 64'(m_count), 64'(cnt));
  endtask

  initial begin
    pc = '0;
    step(1'b1, 16'h0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 16'h0, 1'b0, 1'b1, 1'b1);

    // Streaming, then back-pressure until full, then drain
    stream(12, 1'b1);
    stream(8, 1'b0);
    stream(10, 1'b1);

    // Flush with three queued and one in flight, restart at 0x0040
    fill_to(3);
    step(1'b1, pc, 1'b1, 1'b1, 1'b0);
    pc = 16'h0040;
    stream(6, 1'b1);
    step(1'b0, pc, 1'b1, 1'b1, 1'b0);
    step(1'b0, pc, 1'b1, 1'b1, 1'b0);

    // Steady push+pop at count 2
    fill_to(2);
    stream(10, 1'b1);

    // Wrap-around with a random ready pattern
    for (int i = 0; i < 40; i++) begin
      step(1'b1, pc, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      if (last_issue) pc++;
    end

    // Reset mid-stream with a read in flight
    fill_to(3);
    step(1'b1, pc, 1'b0, 1'b1, 1'b1);
    stream(6, 1'b1);

    // Random mix including occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      bit fl;
      bit rs;
      fl = ($urandom_range(0, 19) == 0);
      rs = ($urandom_range(0, 49) == 0);
      step(($urandom_range(0, 4) != 0), pc, fl, ($urandom_range(0, 2) != 0), rs);
      if (fl || rs) pc = 16'($urandom());
      else if (last_issue) pc++;
    end

    for (int i = 0; i < 8; i++) step(1'b0, pc, 1'b0, 1'b1, 1'b0);
    check("drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
